// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the CortexM0 data-port to SRAM bridge:
//   - DSIZE encodings
//   - bridge FSM state type
//   - size_mask(): byte-lane mask of an access, right-justified
//   - byte_mask32(): expands a 4-bit lane mask to a 32-bit bit mask
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // Reserved size yields an empty mask; such accesses fault before any use.
   function automatic logic [3:0] size_mask(input logic [1:0] dsize);
      case (dsize)
         SZ_BYTE: return 4'h1;
         SZ_HALF: return 4'h3;
         SZ_WORD: return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] byte_mask32(input logic [3:0] lanes);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{lanes[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// dmem_lane_steer
// Combinational byte-lane steering between right-justified core data and
// the two-word (64-bit) view of an access that may straddle a word boundary.
// Ports:
//   off      in  2   byte offset of the access within its first word
//   mask     in  4   right-justified lane mask (1/3/F)
//   data     in  32  core write data, right-justified
//   rbuf     in  64  read buffer, beat 0 in [31:0], beat 1 in [63:32]
//   wide     out 8   lane enables over both beats (mask << off)
//   wdata_sh out 64  write data masked to size and shifted to its lanes
//   rdata    out 32  read data shifted back down and masked to size
module dmem_lane_steer
   import dmem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [3:0]  mask,
   input  logic [31:0] data,
   input  logic [63:0] rbuf,
   output logic [7:0]  wide,
   output logic [63:0] wdata_sh,
   output logic [31:0] rdata
);

   logic [31:0] bmask;
   logic [5:0]  shamt;

   always_comb begin
      bmask    = byte_mask32(mask);
      shamt    = {off, 3'b000};
      wide     = {4'b0000, mask} << off;
      // Masking before the shift keeps unused high bytes of the core's
      // write data off the second beat.
      wdata_sh = {32'h0, data & bmask} << shamt;
      rdata    = 32'(rbuf >> shamt) & bmask;
   end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge
// Sequential bridge from the CortexM0 data port to a word-organised
// synchronous SRAM. Steers byte lanes, splits unaligned halfword/word
// accesses into two SRAM beats, inserts WAIT_STATES per beat and reports
// illegal accesses through DREADY/DFAULT.
// Parameters:
//   ADDR_W          SRAM word-address width
//   WAIT_STATES     extra CAPTURE cycles per beat (0..7)
//   SPLIT_UNALIGNED 1: split straddling accesses, 0: fault them
// Ports:
//   CLK, RESET_N            clock (rising), synchronous active-low reset
//   DREQ/DADDR/DRW/DSIZE/DOUT  core request, held until DREADY
//   DIN/DREADY/DFAULT       core response, DREADY is a one-cycle pulse
//   CSN/ADDR/WE/BE/DI       SRAM command (active only in ISSUE)
//   DO                      SRAM read data, valid the cycle after CSN=0
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int ADDR_W          = 12,
   parameter int WAIT_STATES     = 0,
   parameter int SPLIT_UNALIGNED = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              DREQ,
   input  logic [31:0]       DADDR,
   input  logic              DRW,
   input  logic [1:0]        DSIZE,
   input  logic [31:0]       DOUT,
   output logic [31:0]       DIN,
   output logic              DREADY,
   output logic              DFAULT,
   output logic              CSN,
   output logic [ADDR_W-1:0] ADDR,
   output logic              WE,
   output logic [3:0]        BE,
   output logic [31:0]       DI,
   input  logic [31:0]       DO
);

   localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

   state_t state_q, state_d;

   // Access latches
   logic [1:0]        off_q;
   logic [3:0]        mask_q;
   logic              rw_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W-1:0] waddr_q;

   // Control
   logic              split_q;
   logic              fault_q;
   logic              beat_q;
   logic [2:0]        wait_q;
   logic [63:0]       buf_q;

   // Steering
   logic [1:0]        st_off;
   logic [3:0]        st_mask;
   logic [7:0]        wide;
   logic [63:0]       wdata_sh;
   logic [31:0]       rdata;

   logic              accept;
   logic              accept_split;
   logic              accept_fault;
   logic              wait_done;

   // Byte address bits above the SRAM word range are intentionally ignored.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^DADDR[31:ADDR_W+2];

   // In IDLE the steer unit looks at the live request so the beat count and
   // fault decision are known at acceptance; afterwards it uses the latches.
   always_comb begin
      if (state_q == ST_IDLE) begin
         st_off  = DADDR[1:0];
         st_mask = size_mask(DSIZE);
      end else begin
         st_off  = off_q;
         st_mask = mask_q;
      end
   end

   dmem_lane_steer u_steer (
      .off      (st_off),
      .mask     (st_mask),
      .data     (wdata_q),
      .rbuf     (buf_q),
      .wide     (wide),
      .wdata_sh (wdata_sh),
      .rdata    (rdata)
   );

   always_comb begin
      accept       = (state_q == ST_IDLE) && DREQ;
      accept_split = |wide[7:4];
      accept_fault = (DSIZE == SZ_RSVD) ||
                     (accept_split && (SPLIT_UNALIGNED == 0));
      wait_done    = (wait_q == WAIT_LAST);
   end

   // ---- FSM: state register ----
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (DREQ) begin
               state_d = accept_fault ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (wait_done) begin
               state_d = (!beat_q && split_q) ? ST_ISSUE : ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      CSN    = 1'b1;
      WE     = 1'b0;
      BE     = 4'h0;
      ADDR   = '0;
      DI     = 32'h0;
      DREADY = 1'b0;
      DFAULT = 1'b0;
      DIN    = 32'h0;
      case (state_q)
         ST_ISSUE: begin
            CSN  = 1'b0;
            WE   = rw_q;
            // Second beat wraps naturally at the top of the word space.
            ADDR = waddr_q + {{(ADDR_W-1){1'b0}}, beat_q};
            BE   = beat_q ? wide[7:4] : wide[3:0];
            DI   = beat_q ? wdata_sh[63:32] : wdata_sh[31:0];
         end
         ST_RESP: begin
            DREADY = 1'b1;
            DFAULT = fault_q;
            if (!fault_q && !rw_q) begin
               DIN = rdata;
            end
         end
         default: begin
         end
      endcase
   end

   // ---- Control: beat, wait counter, fault flag, read buffer ----
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         split_q <= 1'b0;
         fault_q <= 1'b0;
         beat_q  <= 1'b0;
         wait_q  <= 3'd0;
         buf_q   <= 64'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  split_q <= accept_split;
                  fault_q <= accept_fault;
                  beat_q  <= 1'b0;
                  wait_q  <= 3'd0;
               end
            end
            ST_ISSUE: begin
               wait_q <= 3'd0;
            end
            ST_CAPTURE: begin
               // SRAM data is valid only in the first CAPTURE cycle of a beat.
               if (wait_q == 3'd0 && !rw_q) begin
                  if (beat_q) begin
                     buf_q[63:32] <= DO;
                  end else begin
                     buf_q[31:0] <= DO;
                  end
               end
               if (wait_done) begin
                  if (!beat_q && split_q) begin
                     beat_q <= 1'b1;
                  end
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---- Request latches ----
   always_ff @(posedge CLK) begin
      if (accept) begin
         off_q   <= DADDR[1:0];
         mask_q  <= size_mask(DSIZE);
         rw_q    <= DRW;
         wdata_q <= DOUT;
         waddr_q <= DADDR[ADDR_W+1:2];
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
// Two bridge instances: u0 (WAIT_STATES=0, split enabled) and
// u1 (WAIT_STATES=2, split disabled), each attached to its own SRAM model.
// A byte-addressed reference memory predicts read data, lane enables,
// write data per beat, latency and fault outcome for every access.
module tb_dmem_bridge;

   logic        clk;
   logic        rst_n;
   logic        tb_init;

   logic        dreq   [2];
   logic [31:0] daddr  [2];
   logic        drw    [2];
   logic [1:0]  dsize  [2];
   logic [31:0] dwr    [2];
   logic [31:0] din    [2];
   logic        dready [2];
   logic        dfault [2];
   logic        csn    [2];
   logic [11:0] saddr  [2];
   logic        we     [2];
   logic [3:0]  be     [2];
   logic [31:0] di     [2];
   logic [31:0] sdo    [2];

   logic [31:0] sram [2][4096];
   logic [7:0]  rmem [2][16384];

   int          ws      [2] = '{0, 2};
   int          split_p [2] = '{1, 0};

   int          n_cmp = 0;
   int          n_err = 0;

   // Last observed access
   logic [11:0] g_addr [2];
   logic [3:0]  g_be   [2];
   logic [31:0] g_di   [2];
   logic [31:0] g_din;
   int          g_lat;
   int          g_nb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_bridge #(.ADDR_W(12), .WAIT_STATES(0), .SPLIT_UNALIGNED(1)) u0 (
      .CLK(clk), .RESET_N(rst_n), .DREQ(dreq[0]), .DADDR(daddr[0]),
      .DRW(drw[0]), .DSIZE(dsize[0]), .DOUT(dwr[0]), .DIN(din[0]),
      .DREADY(dready[0]), .DFAULT(dfault[0]), .CSN(csn[0]), .ADDR(saddr[0]),
      .WE(we[0]), .BE(be[0]), .DI(di[0]), .DO(sdo[0])
   );

   dmem_bridge #(.ADDR_W(12), .WAIT_STATES(2), .SPLIT_UNALIGNED(0)) u1 (
      .CLK(clk), .RESET_N(rst_n), .DREQ(dreq[1]), .DADDR(daddr[1]),
      .DRW(drw[1]), .DSIZE(dsize[1]), .DOUT(dwr[1]), .DIN(din[1]),
      .DREADY(dready[1]), .DFAULT(dfault[1]), .CSN(csn[1]), .ADDR(saddr[1]),
      .WE(we[1]), .BE(be[1]), .DI(di[1]), .DO(sdo[1])
   );

   function automatic logic [31:0] init_word(input int i, input int w);
      return (32'(w) * 32'h9E3779B1) ^ (32'(i) * 32'h5A5A0000) ^ 32'h0000_1234;
   endfunction

   // SRAM models: registered read, byte-enabled write
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (tb_init) begin
            for (int w = 0; w < 4096; w++) sram[i][w] <= init_word(i, w);
         end else if (!csn[i]) begin
            if (we[i]) begin
               for (int k = 0; k < 4; k++)
                  if (be[i][k]) sram[i][saddr[i]][8*k +: 8] <= di[i][8*k +: 8];
            end else begin
               sdo[i] <= sram[i][saddr[i]];
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input int i, input string tag);
      check_val({tag, " DREADY"}, 32'(dready[i]), 32'h0);
      check_val({tag, " DFAULT"}, 32'(dfault[i]), 32'h0);
      check_val({tag, " DIN"},    din[i],          32'h0);
      check_val({tag, " CSN"},    32'(csn[i]),     32'h1);
      check_val({tag, " WE"},     32'(we[i]),      32'h0);
      check_val({tag, " BE"},     32'(be[i]),      32'h0);
      check_val({tag, " ADDR"},   32'(saddr[i]),   32'h0);
      check_val({tag, " DI"},     di[i],           32'h0);
   endtask

   // One complete access on instance i, starting and ending in IDLE
   // (called #1 after a rising edge).
   task automatic access(input int i, input logic [31:0] a, input logic rw,
                         input logic [1:0] sz, input logic [31:0] wd, input string tag);
      int          n, off, exp_beats, exp_lat, lat, nb, lane, b;
      bit          flt, bad_idle;
      logic [3:0]  ebe   [2];
      logic [31:0] edi   [2];
      logic [11:0] eaddr [2];
      logic [31:0] edin, din_s;
      logic        flt_s;

      // Reference prediction
      n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
      off = int'(a[1:0]);
      flt = (sz == 2'b11) || ((off + n > 4) && (split_p[i] == 0));
      exp_beats = flt ? 0 : ((off + n > 4) ? 2 : 1);
      exp_lat   = flt ? 1 : (exp_beats == 1 ? 3 + ws[i] : 5 + 2 * ws[i]);
      for (int q = 0; q < 2; q++) begin
         ebe[q]   = 4'h0;
         edi[q]   = 32'h0;
         eaddr[q] = 12'((a >> 2) + 32'(q));
      end
      edin = 32'h0;
      for (int k = 0; k < n; k++) begin
         lane = off + k;
         b    = lane / 4;
         ebe[b][lane % 4] = 1'b1;
         edi[b][8*(lane % 4) +: 8] = wd[8*k +: 8];
         if (!flt && !rw) edin[8*k +: 8] = rmem[i][(int'(a[13:0]) + k) % 16384];
      end

      // Drive and observe
      dreq[i] = 1'b1; daddr[i] = a; drw[i] = rw; dsize[i] = sz; dwr[i] = wd;
      lat = -1; nb = 0; bad_idle = 0; din_s = 32'h0; flt_s = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            // Core inputs must be ignored once the access is accepted.
            daddr[i] = $urandom; drw[i] = 1'($urandom);
            dsize[i] = 2'($urandom); dwr[i] = $urandom;
         end
         if (!csn[i]) begin
            if (nb < 2) begin
               g_addr[nb] = saddr[i]; g_be[nb] = be[i]; g_di[nb] = di[i];
               if (we[i] !== rw) bad_idle = 1;
            end
            nb++;
         end else if (be[i] != 4'h0 || we[i]) begin
            bad_idle = 1;
         end
         if (dready[i]) begin
            lat = c; din_s = din[i]; flt_s = dfault[i];
            break;
         end
      end
      dreq[i] = 1'b0;
      @(posedge clk); #1;

      check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, " fault"}, 32'(flt_s), 32'(flt));
      check_val({tag, " beats"}, 32'(nb), 32'(exp_beats));
      check_val({tag, " DIN"}, din_s, edin);
      check_val({tag, " quiet"}, 32'(bad_idle), 32'h0);
      check_val({tag, " pulse"}, 32'(dready[i]), 32'h0);
      for (int q = 0; q < exp_beats && q < nb; q++) begin
         check_val($sformatf("%s b%0d ADDR", tag, q), 32'(g_addr[q]), 32'(eaddr[q]));
         check_val($sformatf("%s b%0d BE", tag, q), 32'(g_be[q]), 32'(ebe[q]));
         if (rw) check_val($sformatf("%s b%0d DI", tag, q), g_di[q], edi[q]);
      end
      g_din = din_s; g_lat = lat; g_nb = nb;

      if (!flt && rw)
         for (int k = 0; k < n; k++) rmem[i][(int'(a[13:0]) + k) % 16384] = wd[8*k +: 8];
   endtask

   task automatic reset_mid_read(input int i, input string tag);
      dreq[i] = 1'b1; daddr[i] = 32'h0000_0010; drw[i] = 1'b0;
      dsize[i] = 2'b10; dwr[i] = 32'h0;
      @(posedge clk); #1;          // ISSUE
      @(posedge clk); #1;          // CAPTURE
      rst_n = 1'b0; dreq[i] = 1'b0;
      @(posedge clk); #1;
      check_reset_vals(i, tag);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val({tag, " no DREADY"}, 32'(dready[i]), 32'h0);
   endtask

   initial begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      int          r;

      rst_n = 1'b0; tb_init = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dreq[i] = 1'b0; daddr[i] = 32'h0; drw[i] = 1'b0; dsize[i] = 2'b00; dwr[i] = 32'h0;
         for (int w = 0; w < 4096; w++) begin
            wd = init_word(i, w);
            for (int k = 0; k < 4; k++) rmem[i][4*w + k] = wd[8*k +: 8];
         end
      end
      @(posedge clk); #1;
      tb_init = 1'b0;
      @(posedge clk); #1;
      check_reset_vals(0, "rst u0");
      check_reset_vals(1, "rst u1");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed, instance u0 (no wait states, split enabled)
      access(0, 32'h0000_0100, 1'b1, 2'b10, 32'hDEADBEEF, "wr word");
      check_val("wr word ADDR", 32'(g_addr[0]), 32'h40);
      check_val("wr word DI", g_di[0], 32'hDEADBEEF);
      check_val("wr word lat", 32'(g_lat), 32'd3);
      access(0, 32'h0000_0100, 1'b0, 2'b10, 32'h0, "rd word");
      check_val("rd word data", g_din, 32'hDEADBEEF);
      access(0, 32'h0000_0103, 1'b1, 2'b00, 32'hFFFF_FFA5, "wr byte");
      check_val("wr byte BE", 32'(g_be[0]), 32'h8);
      check_val("wr byte DI", g_di[0], 32'hA500_0000);
      access(0, 32'h0000_0102, 1'b0, 2'b01, 32'h0, "rd half");
      check_val("rd half data", g_din, {16'h0, 8'hA5, 8'hAD});
      access(0, 32'h0000_0206, 1'b1, 2'b10, 32'h11223344, "wr split");
      check_val("wr split b0 DI", g_di[0], 32'h3344_0000);
      check_val("wr split b1 DI", g_di[1], 32'h0000_1122);
      check_val("wr split b1 ADDR", 32'(g_addr[1]), 32'h82);
      access(0, 32'h0000_0206, 1'b0, 2'b10, 32'h0, "rd split");
      check_val("rd split data", g_din, 32'h11223344);
      check_val("rd split lat", 32'(g_lat), 32'd5);
      access(0, 32'h0000_0100, 1'b0, 2'b11, 32'h0, "rsvd");
      check_val("rsvd beats", 32'(g_nb), 32'd0);
      access(0, 32'h0000_3FFE, 1'b1, 2'b10, 32'hCAFE_F00D, "wrap wr");
      check_val("wrap b1 ADDR", 32'(g_addr[1]), 32'h000);
      access(0, 32'hFFFF_3FFE, 1'b0, 2'b10, 32'h0, "wrap rd");
      check_val("wrap rd data", g_din, 32'hCAFE_F00D);

      // Directed, instance u1 (two wait states, split disabled)
      access(1, 32'h0000_0100, 1'b0, 2'b10, 32'h0, "u1 rd");
      check_val("u1 rd lat", 32'(g_lat), 32'd5);
      access(1, 32'h0000_0206, 1'b0, 2'b10, 32'h0, "u1 unal");
      check_val("u1 unal lat", 32'(g_lat), 32'd1);
      check_val("u1 unal beats", 32'(g_nb), 32'd0);

      // Reset in the middle of a read, then a normal access
      reset_mid_read(0, "abort u0");
      access(0, 32'h0000_0010, 1'b0, 2'b10, 32'h0, "post abort u0");
      reset_mid_read(1, "abort u1");
      access(1, 32'h0000_0010, 1'b0, 2'b10, 32'h0, "post abort u1");

      // Randomized accesses against the reference memory
      for (int t = 0; t < 300; t++) begin
         int i;
         i = t % 2;
         if ($urandom_range(0, 7) == 0) a = ($urandom & 32'hFFFF_C000) | 32'(16380 + $urandom_range(0, 3));
         else a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         access(i, a, 1'($urandom), sz, $urandom, $sformatf("rnd%0d u%0d", t, i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
